// File: rtl/chess_clock_pkg.sv
// Shared types and BCD time arithmetic for the chess clock.
// Remaining time is kept as four BCD digits, mm:ss.
package chess_clock_pkg;

  typedef logic [3:0] bcd_digit_t;

  typedef struct packed {
    bcd_digit_t min_tens;
    bcd_digit_t min_ones;
    bcd_digit_t sec_tens;
    bcd_digit_t sec_ones;
  } clock_time_t;

  localparam clock_time_t MAX_TIME   = {4'd9, 4'd9, 4'd5, 4'd9};
  localparam clock_time_t CLOCK_ZERO = {4'd0, 4'd0, 4'd0, 4'd0};

  // One-second BCD decrement with borrow; 00:00 stays at 00:00.
  function automatic clock_time_t bcd_time_dec(input clock_time_t t);
    clock_time_t r;
    r = t;
    if (t == CLOCK_ZERO) begin
      r = t;
    end else if (t.sec_ones != 4'd0) begin
      r.sec_ones = t.sec_ones - 4'd1;
    end else begin
      r.sec_ones = 4'd9;
      if (t.sec_tens != 4'd0) begin
        r.sec_tens = t.sec_tens - 4'd1;
      end else begin
        r.sec_tens = 4'd5;
        if (t.min_ones != 4'd0) begin
          r.min_ones = t.min_ones - 4'd1;
        end else begin
          // t is non-zero here, so min_tens is at least 1
          r.min_ones = 4'd9;
          r.min_tens = t.min_tens - 4'd1;
        end
      end
    end
    return r;
  endfunction

  // BCD add of inc_sec (0..59) seconds with carry, saturating at 99:59.
  function automatic clock_time_t bcd_time_add_sec(input clock_time_t t,
                                                   input logic [5:0] inc_sec);
    logic [5:0] inc_tens;
    logic [5:0] inc_ones;
    logic [5:0] so;
    logic [5:0] st;
    logic [5:0] mo;
    logic [5:0] mt;
    clock_time_t r;
    inc_tens = inc_sec / 6'd10;
    inc_ones = inc_sec % 6'd10;
    so = {2'b00, t.sec_ones} + inc_ones;
    if (so > 6'd9) begin
      so = so - 6'd10;
      st = {2'b00, t.sec_tens} + inc_tens + 6'd1;
    end else begin
      st = {2'b00, t.sec_tens} + inc_tens;
    end
    if (st > 6'd5) begin
      st = st - 6'd6;
      mo = {2'b00, t.min_ones} + 6'd1;
    end else begin
      mo = {2'b00, t.min_ones};
    end
    if (mo > 6'd9) begin
      mo = mo - 6'd10;
      mt = {2'b00, t.min_tens} + 6'd1;
    end else begin
      mt = {2'b00, t.min_tens};
    end
    if (mt > 6'd9) begin
      r = MAX_TIME;
    end else begin
      r = {mt[3:0], mo[3:0], st[3:0], so[3:0]};
    end
    return r;
  endfunction

endpackage

// File: rtl/chess_clock_prescaler.sv
// Divides i_clk by CLK_HZ to produce a one-second tick while enabled.
// The count holds while disabled so a paused sub-second fraction survives.
module chess_clock_prescaler #(
  parameter int CLK_HZ = 100_000_000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_en,
  output logic o_tick
);

  localparam int CW = $clog2(CLK_HZ);
  localparam logic [CW-1:0] LAST = CW'(CLK_HZ - 1);

  logic [CW-1:0] count_r;

  assign o_tick = i_en && (count_r == LAST);

  // Count 0..CLK_HZ-1 while enabled, wrap on the tick, hold otherwise
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      count_r <= {CW{1'b0}};
    end else if (o_tick) begin
      count_r <= {CW{1'b0}};
    end else if (i_en) begin
      count_r <= count_r + CW'(1);
    end else begin
      count_r <= count_r;
    end
  end

endmodule

// File: rtl/chess_clock_timer.sv
// Per-player countdown timer: BCD mm:ss display and a sticky zero flag.
// Optional Fischer increment on a rising edge of i_stop is enabled with the
// macro CHESS_CLOCK_TIMER_INCREMENT_EN.
module chess_clock_timer
  import chess_clock_pkg::*;
#(
  parameter int CLK_HZ   = 100_000_000,
  parameter int INIT_MIN = 5,
  parameter int INC_SEC  = 2
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_restart,
  input  logic       i_stop,
  output logic [3:0] o_min_tens,
  output logic [3:0] o_min_ones,
  output logic [3:0] o_sec_tens,
  output logic [3:0] o_sec_ones,
  output logic       o_zero
);

  localparam clock_time_t INIT_TIME = {4'(INIT_MIN / 10), 4'(INIT_MIN % 10), 4'd0, 4'd0};
  localparam logic        INIT_ZERO = (INIT_MIN == 0) ? 1'b1 : 1'b0;

  clock_time_t time_r;
  clock_time_t time_next_s;
  clock_time_t dec_s;
  logic        zero_r;
  logic        zero_next_s;
  logic        count_en_s;
  logic        tick_s;

  assign count_en_s = !i_stop && !zero_r && !i_restart;
  assign dec_s      = bcd_time_dec(time_r);

  chess_clock_prescaler #(
    .CLK_HZ (CLK_HZ)
  ) u_prescaler (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_clear (i_restart),
    .i_en    (count_en_s),
    .o_tick  (tick_s)
  );

`ifdef CHESS_CLOCK_TIMER_INCREMENT_EN
  localparam logic [5:0] INC_SEC_W = 6'(INC_SEC);

  logic stop_hist_r;
  logic stop_rise_s;

  assign stop_rise_s = !stop_hist_r && i_stop && !zero_r && !i_restart;

  // Remember the previous i_stop level; loads as "paused"
  always_ff @(posedge i_clk) begin
    if (i_rst || i_restart) begin
      stop_hist_r <= 1'b1;
    end else begin
      stop_hist_r <= i_stop;
    end
  end
`endif

  // Next time: restart load, tick decrement, optional increment, else hold
  always_comb begin
    time_next_s = time_r;
    zero_next_s = zero_r;
    if (i_restart) begin
      time_next_s = INIT_TIME;
      zero_next_s = INIT_ZERO;
    end else if (tick_s) begin
      time_next_s = dec_s;
      zero_next_s = (dec_s == CLOCK_ZERO);
    end
`ifdef CHESS_CLOCK_TIMER_INCREMENT_EN
    else if (stop_rise_s) begin
      time_next_s = bcd_time_add_sec(time_r, INC_SEC_W);
      zero_next_s = zero_r;
    end
`endif
    else begin
      time_next_s = time_r;
      zero_next_s = zero_r;
    end
  end

  // Time and zero-flag registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      time_r <= INIT_TIME;
      zero_r <= INIT_ZERO;
    end else begin
      time_r <= time_next_s;
      zero_r <= zero_next_s;
    end
  end

  assign o_min_tens = time_r.min_tens;
  assign o_min_ones = time_r.min_ones;
  assign o_sec_tens = time_r.sec_tens;
  assign o_sec_ones = time_r.sec_ones;
  assign o_zero     = zero_r;

endmodule

// File: tb/tb_chess_clock_timer.sv
// Bench for chess_clock_timer: four instances (INIT_MIN 1, 10, 0, 99) with
// CLK_HZ=4, INC_SEC=2, checked every cycle against a seconds-based model,
// plus directed constant checks. Honours CHESS_CLOCK_TIMER_INCREMENT_EN.
module tb_chess_clock_timer;

  localparam int CLK_HZ  = 4;
  localparam int INC_SEC = 2;

  logic       clk;
  logic [3:0] rst_v;
  logic [3:0] restart_v;
  logic [3:0] stop_v;
  logic [3:0] mt_o [4];
  logic [3:0] mo_o [4];
  logic [3:0] st_o [4];
  logic [3:0] so_o [4];
  logic [3:0] z_o;

  int n_checks = 0;
  int n_errors = 0;

  int init_min [4] = '{1, 10, 0, 99};
  int m_secs [4];
  int m_frac [4];
  bit m_zero [4];
  bit m_prev [4];

  chess_clock_timer #(.CLK_HZ(CLK_HZ), .INIT_MIN(1), .INC_SEC(INC_SEC)) dut_a (
    .i_clk(clk), .i_rst(rst_v[0]), .i_restart(restart_v[0]), .i_stop(stop_v[0]),
    .o_min_tens(mt_o[0]), .o_min_ones(mo_o[0]), .o_sec_tens(st_o[0]),
    .o_sec_ones(so_o[0]), .o_zero(z_o[0]));
  chess_clock_timer #(.CLK_HZ(CLK_HZ), .INIT_MIN(10), .INC_SEC(INC_SEC)) dut_b (
    .i_clk(clk), .i_rst(rst_v[1]), .i_restart(restart_v[1]), .i_stop(stop_v[1]),
    .o_min_tens(mt_o[1]), .o_min_ones(mo_o[1]), .o_sec_tens(st_o[1]),
    .o_sec_ones(so_o[1]), .o_zero(z_o[1]));
  chess_clock_timer #(.CLK_HZ(CLK_HZ), .INIT_MIN(0), .INC_SEC(INC_SEC)) dut_c (
    .i_clk(clk), .i_rst(rst_v[2]), .i_restart(restart_v[2]), .i_stop(stop_v[2]),
    .o_min_tens(mt_o[2]), .o_min_ones(mo_o[2]), .o_sec_tens(st_o[2]),
    .o_sec_ones(so_o[2]), .o_zero(z_o[2]));
  chess_clock_timer #(.CLK_HZ(CLK_HZ), .INIT_MIN(99), .INC_SEC(INC_SEC)) dut_d (
    .i_clk(clk), .i_rst(rst_v[3]), .i_restart(restart_v[3]), .i_stop(stop_v[3]),
    .o_min_tens(mt_o[3]), .o_min_ones(mo_o[3]), .o_sec_tens(st_o[3]),
    .o_sec_ones(so_o[3]), .o_zero(z_o[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed value of instance i: {zero, mm:ss digits}
  function automatic logic [16:0] dut_val(input int i);
    return {z_o[i], mt_o[i], mo_o[i], st_o[i], so_o[i]};
  endfunction

  // Expected value from the model's remaining seconds
  function automatic logic [16:0] model_val(input int i);
    int mm;
    int ss;
    mm = m_secs[i] / 60;
    ss = m_secs[i] % 60;
    return {m_zero[i], 4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
  endfunction

  // Advance the model of instance i by one clock edge
  task automatic model_step(input int i);
    if (rst_v[i] || restart_v[i]) begin
      m_secs[i] = init_min[i] * 60;
      m_frac[i] = 0;
      m_zero[i] = (m_secs[i] == 0);
      m_prev[i] = 1'b1;
    end else begin
      if (!stop_v[i] && !m_zero[i]) begin
        if (m_frac[i] == CLK_HZ - 1) begin
          m_frac[i] = 0;
          m_secs[i] = m_secs[i] - 1;
          if (m_secs[i] == 0) m_zero[i] = 1'b1;
        end else begin
          m_frac[i] = m_frac[i] + 1;
        end
      end
`ifdef CHESS_CLOCK_TIMER_INCREMENT_EN
      if (!m_prev[i] && stop_v[i] && !m_zero[i]) begin
        m_secs[i] = m_secs[i] + INC_SEC;
        if (m_secs[i] > 5999) m_secs[i] = 5999;
      end
`endif
      m_prev[i] = stop_v[i];
    end
  endtask

  task automatic chk(input string tag, input logic [16:0] obs, input logic [16:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Run n clock edges, stepping the model and comparing every instance
  task automatic cyc(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      for (int i = 0; i < 4; i++) model_step(i);
      #1;
      for (int i = 0; i < 4; i++) chk($sformatf("model_dut%0d", i), dut_val(i), model_val(i));
    end
  endtask

  initial begin
    rst_v = 4'hF;
    restart_v = 4'h0;
    stop_v = 4'hF;
    cyc(2);
    rst_v = 4'h0;
    chk("reset_a", dut_val(0), {1'b0, 16'h0100});
    chk("reset_b", dut_val(1), {1'b0, 16'h1000});
    chk("reset_c", dut_val(2), {1'b1, 16'h0000});
    chk("reset_d", dut_val(3), {1'b0, 16'h9900});

    // First tick lands on the 4th counting edge; B shows the borrow chain
    stop_v = 4'b1000;
    cyc(3);
    chk("pre_tick_a", dut_val(0), {1'b0, 16'h0100});
    cyc(1);
    chk("tick_a", dut_val(0), {1'b0, 16'h0059});
    chk("borrow_b", dut_val(1), {1'b0, 16'h0959});
    cyc(36);
    chk("ten_sec_b", dut_val(1), {1'b0, 16'h0950});
    cyc(199);
    chk("one_left_a", dut_val(0), {1'b0, 16'h0001});
    cyc(1);
    chk("zero_a", dut_val(0), {1'b1, 16'h0000});
    chk("minute_b", dut_val(1), {1'b0, 16'h0900});
    chk("zero_init_c", dut_val(2), {1'b1, 16'h0000});
    cyc(20);
    chk("zero_hold_a", dut_val(0), {1'b1, 16'h0000});
    stop_v[0] = 1'b1;
    cyc(1);
    chk("zero_no_inc_a", dut_val(0), {1'b1, 16'h0000});

    // Pause mid-second
    stop_v = 4'hF;
    rst_v[0] = 1'b1;
    cyc(1);
    rst_v[0] = 1'b0;
    stop_v[0] = 1'b0;
    cyc(2);
    stop_v[0] = 1'b1;
    cyc(50);
`ifdef CHESS_CLOCK_TIMER_INCREMENT_EN
    chk("pause_hold_a", dut_val(0), {1'b0, 16'h0102});
`else
    chk("pause_hold_a", dut_val(0), {1'b0, 16'h0100});
`endif
    stop_v[0] = 1'b0;
    cyc(2);
`ifdef CHESS_CLOCK_TIMER_INCREMENT_EN
    chk("pause_resume_a", dut_val(0), {1'b0, 16'h0101});
`else
    chk("pause_resume_a", dut_val(0), {1'b0, 16'h0059});
`endif

    // Restart at 00:37, then restart and reset coinciding with a tick
    rst_v[0] = 1'b1;
    cyc(1);
    rst_v[0] = 1'b0;
    cyc(92);
    chk("at_37_a", dut_val(0), {1'b0, 16'h0037});
    restart_v[0] = 1'b1;
    cyc(1);
    restart_v[0] = 1'b0;
    chk("restart_a", dut_val(0), {1'b0, 16'h0100});
    cyc(3);
    chk("restart_presc0_a", dut_val(0), {1'b0, 16'h0100});
    cyc(1);
    chk("restart_tick_a", dut_val(0), {1'b0, 16'h0059});
    cyc(3);
    restart_v[0] = 1'b1;
    cyc(1);
    restart_v[0] = 1'b0;
    chk("restart_on_tick_a", dut_val(0), {1'b0, 16'h0100});
    cyc(3);
    chk("after_rs_hold_a", dut_val(0), {1'b0, 16'h0100});
    cyc(1);
    chk("after_rs_tick_a", dut_val(0), {1'b0, 16'h0059});
    cyc(3);
    rst_v[0] = 1'b1;
    cyc(1);
    rst_v[0] = 1'b0;
    chk("rst_on_tick_a", dut_val(0), {1'b0, 16'h0100});
    cyc(4);
    chk("after_rst_tick_a", dut_val(0), {1'b0, 16'h0059});

    // Increment at 00:58
    rst_v[0] = 1'b1;
    cyc(1);
    rst_v[0] = 1'b0;
    cyc(8);
    chk("at_58_a", dut_val(0), {1'b0, 16'h0058});
    stop_v[0] = 1'b1;
    cyc(1);
`ifdef CHESS_CLOCK_TIMER_INCREMENT_EN
    chk("inc_a", dut_val(0), {1'b0, 16'h0100});
`else
    chk("inc_a", dut_val(0), {1'b0, 16'h0058});
`endif
    cyc(3);
`ifdef CHESS_CLOCK_TIMER_INCREMENT_EN
    chk("inc_once_a", dut_val(0), {1'b0, 16'h0100});
`else
    chk("inc_once_a", dut_val(0), {1'b0, 16'h0058});
`endif

    // Saturation on D: 33 low/high rounds reach 99:58, the 34th saturates
    stop_v = 4'hF;
    rst_v[3] = 1'b1;
    cyc(1);
    rst_v[3] = 1'b0;
    for (int r = 0; r < 33; r++) begin
      stop_v[3] = 1'b0;
      cyc(1);
      stop_v[3] = 1'b1;
      cyc(1);
    end
`ifdef CHESS_CLOCK_TIMER_INCREMENT_EN
    chk("at_9958_d", dut_val(3), {1'b0, 16'h9958});
`else
    chk("at_9958_d", dut_val(3), {1'b0, 16'h9852});
`endif
    stop_v[3] = 1'b0;
    cyc(1);
    stop_v[3] = 1'b1;
    cyc(1);
`ifdef CHESS_CLOCK_TIMER_INCREMENT_EN
    chk("sat_d", dut_val(3), {1'b0, 16'h9959});
`else
    chk("sat_d", dut_val(3), {1'b0, 16'h9852});
`endif

    // Randomized phase with sticky stop levels and rare restart/reset
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(7) == 0) stop_v[i] = ~stop_v[i];
        restart_v[i] = ($urandom_range(63) == 0);
        rst_v[i] = ($urandom_range(255) == 0);
      end
      cyc(1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/chess_clock_timer.md
Name: chess_clock_timer

Overview:
- Per-player countdown timer for the chess clock, instantiated once per player beside the clock FSM.
- Consumes the FSM's per-player stop and restart outputs; produces the per-player zero flag that the FSM samples to declare a win.
- Keeps remaining time as BCD mm:ss for the display driver.

Parameters:
- CLK_HZ, 100_000_000, i_clk frequency; the prescaler divides by this to make a 1 s tick. Must be ≥ 2.
- INIT_MIN, 5, minutes loaded on reset/restart; range 0..99.
- INC_SEC, 2, per-move increment in seconds, used only with the optional feature; range 0..59.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset, synchronous, active-high
- i_restart  in  1  reload initial time; level, priority over everything except i_rst
- i_stop  in  1  1 = clock paused (not this player's turn), 0 = counting
- o_min_tens  out  4  BCD minutes tens digit
- o_min_ones  out  4  BCD minutes ones digit
- o_sec_tens  out  4  BCD seconds tens digit, 0..5
- o_sec_ones  out  4  BCD seconds ones digit
- o_zero  out  1  remaining time is 00:00

Behaviour:
- All outputs are registered; no combinational path from input to output.
- Reset/restart values:
  - prescaler = 0
  - time = INIT_MIN:00 (tens = INIT_MIN/10, ones = INIT_MIN%10)
  - o_zero = (INIT_MIN == 0)
  - i_stop history register = 1
- i_restart held high keeps the block in the loaded state every cycle.
- Prescaler:
  - Counts 0..CLK_HZ-1 only while i_stop=0 and o_zero=0.
  - Holds its value while i_stop=1, so the sub-second fraction is preserved across pauses.
  - Frozen at 0 once o_zero=1.
- Tick: the cycle where the prescaler equals CLK_HZ-1 and counting is enabled. On that cycle:
  - prescaler wraps to 0;
  - time decrements by 1 s on the next edge.
  - The first tick after counting starts from prescaler=0 comes CLK_HZ cycles later.
- Decrement, BCD with borrow:
  - sec_ones 0 → 9 with borrow into sec_tens;
  - sec_tens 0 → 5 with borrow into min_ones;
  - min_ones 0 → 9 with borrow into min_tens.
  - Never decrements below 00:00.
- o_zero:
  - Set on the same edge the digits become 00:00; stays 1 until reset or restart.
  - No further ticks occur while it is set.
- Pausing (i_stop=1) in the tick cycle suppresses that tick; the prescaler holds at CLK_HZ-1.
- Invalid BCD states are unreachable; digits are updated only via load and the decrement/increment rules.

Optional Feature:
- Macro: CHESS_CLOCK_TIMER_INCREMENT_EN
- Defined (Fischer increment):
  - Trigger: a rising edge of i_stop (history=0, i_stop=1), with o_zero=0 and i_restart=0.
  - Action: adds INC_SEC seconds on the next edge, BCD add with carry through sec_ones, sec_tens (mod 60 → min), min_ones, min_tens.
  - Saturates at 99:59.
  - Never coincides with a tick, because ticks need i_stop=0.
  - Prescaler is unchanged.
- Not defined: the i_stop history register and the adder are absent; INC_SEC is ignored.

Decomposition:
- Package chess_clock_pkg:
  - typedef bcd_digit_t (logic [3:0]);
  - packed struct clock_time_t {min_tens, min_ones, sec_tens, sec_ones};
  - constant MAX_TIME (99:59);
  - functions bcd_time_dec and bcd_time_add_sec.
- Sub-module chess_clock_prescaler:
  - parameter CLK_HZ; inputs i_clk, i_rst, i_clear, i_en; output o_tick;
  - counter width $clog2(CLK_HZ).

Test Plan (CLK_HZ=4, INIT_MIN=1, INC_SEC=2):
- Reset → 01:00, o_zero=0. i_stop=0 for 4 cycles → 00:59 on the 4th edge. After 60 s (240 cycles) → 00:00 with o_zero=1 on that same edge; stays 00:00 for 20 more cycles.
- Borrow chain: INIT_MIN=10 → after one tick 09:59; after 10 s 09:50.
- Pause mid-second: i_stop=0 for 2 cycles, 1 for 50 cycles, 0 for 2 cycles → exactly one decrement, to 00:59 (INIT_MIN=1); display unchanged during the pause.
- i_restart pulse at 00:37 with i_stop=0 → 01:00 next edge, prescaler 0, o_zero=0. i_restart asserted together with a tick → 01:00, no decrement. Repeat with i_rst → same result.
- INIT_MIN=0 → o_zero=1 from reset; no counting with i_stop=0.
- With CHESS_CLOCK_TIMER_INCREMENT_EN:
  - at 00:58, i_stop 0→1 → 01:00;
  - at 99:58 → 99:59 (saturation);
  - at o_zero=1 no change;
  - without the macro, the same stimulus leaves 00:58.
